// File: rtl/pps_tick_gen.sv
// -----------------------------------------------------------------------------
// pps_tick_gen
// Programmable PPS / gate generator. Emits a one-cycle tick and a
// programmable-width pulse every period_q clocks, keeps a count of ticks
// issued, and accepts period/width updates that take effect only at a period
// start, so a running gate is never shortened or stretched part-way through.
//
// Ports
//   clk_i       clock (ps_clk domain)
//   rst_i       asynchronous active-high reset
//   en_i        run enable (level)
//   period_i    new period, sampled on cfg_wr_i
//   width_i     new pulse width, sampled on cfg_wr_i
//   cfg_wr_i    one-cycle configuration write strobe
//   cfg_ack_o   one-cycle pulse when the pending configuration becomes active
//   ext_pps_i   external alignment pulse (one cycle, already synchronised)
//   pps_o       pulse, high for width_q clocks from each period start
//   pps_flag_o  one-cycle tick at each period start
//   count_o     position within the current period
//   sec_o       number of ticks issued
//
// Build option
//   PPS_TICK_GEN_EXT_SYNC_EN : when defined, ext_pps_i in RUN forces a period
//   start on the next edge. When undefined, ext_pps_i is ignored.
// -----------------------------------------------------------------------------
module pps_tick_gen #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned DEFAULT_PERIOD = 100000000,
   parameter int unsigned DEFAULT_PWIDTH = 1000,
   parameter int unsigned SEC_WIDTH      = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [WIDTH-1:0]     period_i,
   input  logic [WIDTH-1:0]     width_i,
   input  logic                 cfg_wr_i,
   output logic                 cfg_ack_o,
   input  logic                 ext_pps_i,
   output logic                 pps_o,
   output logic                 pps_flag_o,
   output logic [WIDTH-1:0]     count_o,
   output logic [SEC_WIDTH-1:0] sec_o
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      count_q, count_d;
   logic                  pps_q, pps_d;
   logic                  flag_q, flag_d;
   logic                  ack_q, ack_d;
   logic [SEC_WIDTH-1:0]  sec_q, sec_d;
   logic [WIDTH-1:0]      period_q, period_d;
   logic [WIDTH-1:0]      width_q, width_d;
   logic [WIDTH-1:0]      pend_period_q, pend_period_d;
   logic [WIDTH-1:0]      pend_width_q, pend_width_d;
   logic                  pending_q, pending_d;

   logic [WIDTH-1:0]      count_inc_s;
   logic                  wrap_s;
   logic                  ext_start_s;
   logic                  start_s;
   logic                  apply_s;
   logic [WIDTH-1:0]      eff_width_s;
   logic [WIDTH-1:0]      clamp_period_s;

   // A period shorter than 2 would leave no room for a low pulse phase.
   function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] p);
      if (p < WIDTH'(2)) begin
         return WIDTH'(2);
      end else begin
         return p;
      end
   endfunction

   // Width is kept below the period so pps_o always has at least one low cycle.
   function automatic logic [WIDTH-1:0] clamp_width(input logic [WIDTH-1:0] w,
                                                    input logic [WIDTH-1:0] p);
      if (w >= p) begin
         return p - WIDTH'(1);
      end else begin
         return w;
      end
   endfunction

   assign count_inc_s    = count_q + WIDTH'(1);
   assign wrap_s         = (count_q == (period_q - WIDTH'(1)));
   assign clamp_period_s = clamp_period(period_i);

`ifdef PPS_TICK_GEN_EXT_SYNC_EN
   // A pulse landing on count 0 would duplicate the start that just happened.
   assign ext_start_s = ext_pps_i && (count_q != {WIDTH{1'b0}});
`else
   logic unused_ext_s;
   assign unused_ext_s = ext_pps_i;
   assign ext_start_s  = 1'b0;
`endif

   // Next-state, period-start, config-apply and config-capture logic.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      pps_d         = pps_q;
      flag_d        = 1'b0;
      ack_d         = 1'b0;
      sec_d         = sec_q;
      period_d      = period_q;
      width_d       = width_q;
      pend_period_d = pend_period_q;
      pend_width_d  = pend_width_q;
      pending_d     = pending_q;
      start_s       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            count_d = {WIDTH{1'b0}};
            pps_d   = 1'b0;
            if (en_i) begin
               state_d = ST_RUN;
               start_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!en_i) begin
               state_d = ST_IDLE;
               count_d = {WIDTH{1'b0}};
               pps_d   = 1'b0;
            end else if (wrap_s || ext_start_s) begin
               start_s = 1'b1;
            end else begin
               count_d = count_inc_s;
               pps_d   = (count_inc_s < width_q);
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = {WIDTH{1'b0}};
            pps_d   = 1'b0;
         end
      endcase

      // pending_q is registered, so a write is never applied on its own capture edge.
      apply_s = pending_q && (start_s || (state_q == ST_IDLE));

      if (apply_s) begin
         period_d    = pend_period_q;
         width_d     = pend_width_q;
         ack_d       = 1'b1;
         eff_width_s = pend_width_q;
      end else begin
         eff_width_s = width_q;
      end

      if (start_s) begin
         count_d = {WIDTH{1'b0}};
         flag_d  = 1'b1;
         pps_d   = (eff_width_s != {WIDTH{1'b0}});
         sec_d   = sec_q + SEC_WIDTH'(1);
      end else begin
         sec_d   = sec_q;
      end

      // A write in the apply cycle becomes the new pending value; the ack belongs to the old one.
      if (cfg_wr_i) begin
         pend_period_d = clamp_period_s;
         pend_width_d  = clamp_width(width_i, clamp_period_s);
         pending_d     = 1'b1;
      end else if (apply_s) begin
         pending_d     = 1'b0;
      end else begin
         pending_d     = pending_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         count_q       <= {WIDTH{1'b0}};
         pps_q         <= 1'b0;
         flag_q        <= 1'b0;
         ack_q         <= 1'b0;
         sec_q         <= {SEC_WIDTH{1'b0}};
         period_q      <= WIDTH'(DEFAULT_PERIOD);
         width_q       <= WIDTH'(DEFAULT_PWIDTH);
         pend_period_q <= WIDTH'(DEFAULT_PERIOD);
         pend_width_q  <= WIDTH'(DEFAULT_PWIDTH);
         pending_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         pps_q         <= pps_d;
         flag_q        <= flag_d;
         ack_q         <= ack_d;
         sec_q         <= sec_d;
         period_q      <= period_d;
         width_q       <= width_d;
         pend_period_q <= pend_period_d;
         pend_width_q  <= pend_width_d;
         pending_q     <= pending_d;
      end
   end

   assign count_o    = count_q;
   assign pps_o      = pps_q;
   assign pps_flag_o = flag_q;
   assign cfg_ack_o  = ack_q;
   assign sec_o      = sec_q;

endmodule
